ap_ctrl_perf_monitor: RTL

Synthesizable, parametrised performance monitor for up to NUM_CH HLS blocks using the ap_ctrl_hs/ap_ctrl_chain handshake. It sits beside the kernel top and taps each block's ap_start/ap_ready/ap_done/ap_continue and one loop-iteration pulse per block. Per channel it keeps a tracking FSM and saturating counters for invocations, completions, busy, stall and latency statistics. It also counts loop iterations and flags protocol errors. Results are read through a registered select/read port, so the bench and on-board debug logic get the same numbers.

---
 rtl/ap_ctrl_perf_monitor.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ap_ctrl_perf_monitor.sv
// Performance monitor for ap_ctrl_hs / ap_ctrl_chain HLS blocks: a per-channel call
// tracking FSM, saturating statistics counters and a registered select/read port.
module ap_ctrl_perf_monitor #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [NUM_CH-1:0] iter_done,
  input  logic              rd_req,
  input  logic [3:0]        rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              err_any
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  state_e           state_q [NUM_CH];
  state_e           state_d [NUM_CH];
  logic [CNT_W-1:0] lat_q   [NUM_CH];
  logic [CNT_W-1:0] lat_d   [NUM_CH];
  logic [CNT_W-1:0] inv_q   [NUM_CH];
  logic [CNT_W-1:0] inv_d   [NUM_CH];
  logic [CNT_W-1:0] comp_q  [NUM_CH];
  logic [CNT_W-1:0] comp_d  [NUM_CH];
  logic [CNT_W-1:0] busy_q  [NUM_CH];
  logic [CNT_W-1:0] busy_d  [NUM_CH];
  logic [CNT_W-1:0] stall_q [NUM_CH];
  logic [CNT_W-1:0] stall_d [NUM_CH];
  logic [CNT_W-1:0] last_q  [NUM_CH];
  logic [CNT_W-1:0] last_d  [NUM_CH];
  logic [CNT_W-1:0] max_q   [NUM_CH];
  logic [CNT_W-1:0] max_d   [NUM_CH];
  logic [CNT_W-1:0] iter_q  [NUM_CH];
  logic [CNT_W-1:0] iter_d  [NUM_CH];
  logic [NUM_CH-1:0] err_q;
  logic [NUM_CH-1:0] err_d;

  logic              rd_valid_q;
  logic [CNT_W-1:0]  rd_data_q;
  logic [CNT_W-1:0]  rd_mux_s;
  logic              err_any_q;

  // Per-channel call tracking and statistics next-state
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      lat_d[i]   = lat_q[i];
      inv_d[i]   = inv_q[i];
      comp_d[i]  = comp_q[i];
      busy_d[i]  = busy_q[i];
      stall_d[i] = stall_q[i];
      last_d[i]  = last_q[i];
      max_d[i]   = max_q[i];
      iter_d[i]  = iter_q[i];

      case (state_q[i])
        ST_IDLE: begin
          if (ap_start[i]) begin
            state_d[i] = ST_RUN;
            lat_d[i]   = CNT_ONE;
          end else begin
            state_d[i] = ST_IDLE;
          end
          if (ap_done[i]) begin
            err_d[i] = 1'b1;
          end else begin
            err_d[i] = err_q[i];
          end
        end
        ST_RUN: begin
          lat_d[i] = sat_inc(lat_q[i]);
          if (enable) begin
            busy_d[i] = sat_inc(busy_q[i]);
          end else begin
            busy_d[i] = busy_q[i];
          end
          if (ap_done[i]) begin
            if (enable) begin
              comp_d[i] = sat_inc(comp_q[i]);
              last_d[i] = lat_q[i];
              max_d[i]  = (lat_q[i] > max_q[i]) ? lat_q[i] : max_q[i];
            end else begin
              comp_d[i] = comp_q[i];
            end
            // Chained call: a start accepted on the done cycle opens a fresh measurement
            if (!ap_continue[i]) begin
              state_d[i] = ST_HOLD;
            end else if (ap_start[i]) begin
              state_d[i] = ST_RUN;
              lat_d[i]   = CNT_ONE;
            end else begin
              state_d[i] = ST_IDLE;
            end
          end else begin
            state_d[i] = ST_RUN;
          end
        end
        ST_HOLD: begin
          if (enable) begin
            stall_d[i] = sat_inc(stall_q[i]);
          end else begin
            stall_d[i] = stall_q[i];
          end
          if (!ap_continue[i]) begin
            state_d[i] = ST_HOLD;
          end else if (ap_start[i]) begin
            state_d[i] = ST_RUN;
            lat_d[i]   = CNT_ONE;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase

      if (enable && ap_start[i] && ap_ready[i]) begin
        inv_d[i] = sat_inc(inv_q[i]);
      end else begin
        inv_d[i] = inv_q[i];
      end
      if (enable && iter_done[i]) begin
        iter_d[i] = sat_inc(iter_q[i]);
      end else begin
        iter_d[i] = iter_q[i];
      end

      // Clear wins over same-cycle increments but leaves the tracking FSM alone
      if (clear) begin
        inv_d[i]   = CNT_ZERO;
        comp_d[i]  = CNT_ZERO;
        busy_d[i]  = CNT_ZERO;
        stall_d[i] = CNT_ZERO;
        last_d[i]  = CNT_ZERO;
        max_d[i]   = CNT_ZERO;
        iter_d[i]  = CNT_ZERO;
        err_d[i]   = 1'b0;
      end else begin
        err_d[i]   = err_d[i];
      end
    end
  end

  // Read select mux over the current (pre-update) register values
  always_comb begin
    rd_mux_s = CNT_ZERO;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == i[3:0]) begin
        case (rd_sel)
          3'd0:    rd_mux_s = inv_q[i];
          3'd1:    rd_mux_s = comp_q[i];
          3'd2:    rd_mux_s = busy_q[i];
          3'd3:    rd_mux_s = stall_q[i];
          3'd4:    rd_mux_s = last_q[i];
          3'd5:    rd_mux_s = max_q[i];
          3'd6:    rd_mux_s = iter_q[i];
          3'd7:    rd_mux_s = {{(CNT_W-3){1'b0}}, err_q[i], state_q[i]};
          default: rd_mux_s = CNT_ZERO;
        endcase
      end
    end
  end

  // State, statistics and read port registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        lat_q[i]   <= CNT_ZERO;
        inv_q[i]   <= CNT_ZERO;
        comp_q[i]  <= CNT_ZERO;
        busy_q[i]  <= CNT_ZERO;
        stall_q[i] <= CNT_ZERO;
        last_q[i]  <= CNT_ZERO;
        max_q[i]   <= CNT_ZERO;
        iter_q[i]  <= CNT_ZERO;
      end
      err_q      <= {NUM_CH{1'b0}};
      rd_valid_q <= 1'b0;
      rd_data_q  <= CNT_ZERO;
      err_any_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        lat_q[i]   <= lat_d[i];
        inv_q[i]   <= inv_d[i];
        comp_q[i]  <= comp_d[i];
        busy_q[i]  <= busy_d[i];
        stall_q[i] <= stall_d[i];
        last_q[i]  <= last_d[i];
        max_q[i]   <= max_d[i];
        iter_q[i]  <= iter_d[i];
      end
      err_q      <= err_d;
      rd_valid_q <= rd_req;
      rd_data_q  <= rd_req ? rd_mux_s : CNT_ZERO;
      err_any_q  <= |err_q;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign err_any  = err_any_q;

endmodule
